nmea_sentence_framer: RTL and testbench

Consumes the byte stream from the GPS RS-232 receiver (9600-baud NMEA-0183 source on the GPIO expansion header) and frames complete `$...*hh<CR><LF>` sentences. It verifies the XOR checksum and publishes only valid sentence bodies through a double-buffered line store, so the processor reads whole sentences instead of polling raw UART bytes. It sits directly downstream of the GPS UART receiver and upstream of the Avalon-facing register/read port.

---
 rtl/nmea_sentence_framer_pkg.sv | 44 ++++
 rtl/nmea_sentence_framer_if.sv | 29 ++
 rtl/nmea_sentence_framer_line_buffer.sv | 35 +++
 rtl/nmea_sentence_framer.sv | 171 +++++++++++++++++
 tb/tb_nmea_sentence_framer.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/nmea_sentence_framer_pkg.sv
// Shared types and helpers for the NMEA-0183 sentence framer:
// FSM states, ASCII framing constants, the hex-digit decoder and
// a saturating counter increment.
package nmea_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_BODY    = 3'd1,
        S_CS_HI   = 3'd2,
        S_CS_LO   = 3'd3,
        S_WAIT_CR = 3'd4,
        S_WAIT_LF = 3'd5
    } state_t;

    localparam logic [7:0] ASCII_DOLLAR = 8'h24;
    localparam logic [7:0] ASCII_STAR   = 8'h2A;
    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_LF     = 8'h0A;

    typedef struct packed {
        logic       valid;
        logic [3:0] value;
    } hex_t;

    // Decode one ASCII hex digit; upper and lower case letters are both accepted.
    function automatic hex_t hex_nibble(input logic [7:0] c);
        hex_t h;
        h.valid = 1'b1;
        h.value = 4'h0;
        if (c >= 8'h30 && c <= 8'h39)
            h.value = c[3:0];
        else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
            h.value = c[3:0] + 4'd9;
        else
            h.valid = 1'b0;
        return h;
    endfunction

    // Error counters stick at 255 rather than wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/nmea_sentence_framer_if.sv
// Byte-stream input, published-sentence read port and error counters
// of the NMEA sentence framer. The framer takes the slave side; the
// consumer (UART + register port, or a bench) takes the master side.
interface nmea_sentence_framer_if #(parameter int MAX_LEN = 82) ();
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int AW = $clog2(MAX_LEN);

    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_err;
    logic          sent_valid;
    logic [LW-1:0] sent_len;
    logic          sent_ack;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic [7:0]    cs_err_cnt;
    logic [7:0]    fmt_err_cnt;
    logic [7:0]    drop_cnt;

    modport master (
        output rx_data, rx_valid, rx_err, sent_ack, rd_addr,
        input  sent_valid, sent_len, rd_data, cs_err_cnt, fmt_err_cnt, drop_cnt
    );

    modport slave (
        input  rx_data, rx_valid, rx_err, sent_ack, rd_addr,
        output sent_valid, sent_len, rd_data, cs_err_cnt, fmt_err_cnt, drop_cnt
    );
endinterface

// File: rtl/nmea_sentence_framer_line_buffer.sv
// Ping-pong sentence store: two MAX_LEN-byte banks, one write port and
// one registered read port, shaped for block-RAM inference.
module nmea_line_buffer #(
    parameter int MAX_LEN = 82,
    parameter int AW      = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_sel,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);
    logic [7:0] mem [2][MAX_LEN];

    // Write the fill bank.
    // NOTE: the array itself has no reset so it can map onto block RAM; only the read register is reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_sel][wr_addr] <= wr_data;
    end

    // Registered read of the publish bank; addresses past the bank read as zero.
    always_ff @(posedge clk) begin
        if (!reset_n)
            rd_data <= 8'h00;
        else if (rd_addr < AW'(MAX_LEN))
            rd_data <= mem[rd_sel][rd_addr];
        else
            rd_data <= 8'h00;
    end
endmodule

// File: rtl/nmea_sentence_framer.sv
// Frames $<body>*hh<CR>[<LF>] NMEA sentences from a UART byte stream,
// verifies the XOR checksum and publishes valid bodies through a
// ping-pong line buffer.
// Build option NMEA_CRLF_STRICT_EN: when defined, CR must be followed by LF
// to complete a sentence; otherwise CR completes it and a stray LF is ignored.
module nmea_sentence_framer
    import nmea_pkg::*;
#(
    parameter int MAX_LEN        = 82,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                         clk,
    input  logic                         reset_n,
    nmea_sentence_framer_if.slave        bus
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int AW = $clog2(MAX_LEN);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    state_t        state, state_n;
    logic [LW-1:0] len, len_n;
    logic [7:0]    run_xor, run_xor_n;
    logic [3:0]    cs_hi, cs_hi_n;
    logic          cs_ok, cs_ok_n;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    logic          buf_we, abort, done;
    logic          pub_sel;
    hex_t          hx;

    assign hx      = hex_nibble(bus.rx_data);
    assign tmo_hit = !bus.rx_valid && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Next-state, sentence datapath and abort/complete decode.
    // NOTE: every output is given a default first so no path leaves a latch.
    always_comb begin
        state_n   = state;
        len_n     = len;
        run_xor_n = run_xor;
        cs_hi_n   = cs_hi;
        cs_ok_n   = cs_ok;
        buf_we    = 1'b0;
        abort     = 1'b0;
        done      = 1'b0;
        if (state != S_IDLE && (bus.rx_err || tmo_hit)) begin
            abort   = 1'b1;
            state_n = S_IDLE;
        end else if (bus.rx_valid) begin
            if (bus.rx_data == ASCII_DOLLAR) begin
                abort     = (state != S_IDLE);
                state_n   = S_BODY;
                len_n     = '0;
                run_xor_n = 8'h00;
            end else begin
                case (state)
                    S_IDLE: ;
                    S_BODY: begin
                        if (bus.rx_data == ASCII_STAR) begin
                            state_n = S_CS_HI;
                        end else if (len == LW'(MAX_LEN)) begin
                            abort   = 1'b1;
                            state_n = S_IDLE;
                        end else begin
                            buf_we    = 1'b1;
                            run_xor_n = run_xor ^ bus.rx_data;
                            len_n     = len + LW'(1);
                        end
                    end
                    S_CS_HI: begin
                        if (hx.valid) begin
                            cs_hi_n = hx.value;
                            state_n = S_CS_LO;
                        end else begin
                            abort   = 1'b1;
                            state_n = S_IDLE;
                        end
                    end
                    S_CS_LO: begin
                        if (hx.valid) begin
                            cs_ok_n = ({cs_hi, hx.value} == run_xor);
                            state_n = S_WAIT_CR;
                        end else begin
                            abort   = 1'b1;
                            state_n = S_IDLE;
                        end
                    end
                    S_WAIT_CR: begin
                        if (bus.rx_data == ASCII_CR) begin
`ifdef NMEA_CRLF_STRICT_EN
                            state_n = S_WAIT_LF;
`else
                            done    = 1'b1;
                            state_n = S_IDLE;
`endif
                        end else begin
                            abort   = 1'b1;
                            state_n = S_IDLE;
                        end
                    end
                    S_WAIT_LF: begin
                        done    = (bus.rx_data == ASCII_LF);
                        abort   = (bus.rx_data != ASCII_LF);
                        state_n = S_IDLE;
                    end
                    default: state_n = S_IDLE;
                endcase
            end
        end
    end

    // FSM and sentence registers; the timeout counter idles at zero.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            len     <= '0;
            run_xor <= 8'h00;
            cs_hi   <= 4'h0;
            cs_ok   <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            state   <= state_n;
            len     <= len_n;
            run_xor <= run_xor_n;
            cs_hi   <= cs_hi_n;
            cs_ok   <= cs_ok_n;
            if (state_n == S_IDLE || bus.rx_valid)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    // Publish slot: swap banks on a good sentence, release on ack, count errors.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pub_sel         <= 1'b0;
            bus.sent_valid  <= 1'b0;
            bus.sent_len    <= '0;
            bus.cs_err_cnt  <= 8'h00;
            bus.fmt_err_cnt <= 8'h00;
            bus.drop_cnt    <= 8'h00;
        end else begin
            if (abort)
                bus.fmt_err_cnt <= sat_inc(bus.fmt_err_cnt);
            if (done && !cs_ok)
                bus.cs_err_cnt <= sat_inc(bus.cs_err_cnt);
            if (done && cs_ok && bus.sent_valid && !bus.sent_ack)
                bus.drop_cnt <= sat_inc(bus.drop_cnt);
            if (done && cs_ok && (!bus.sent_valid || bus.sent_ack)) begin
                pub_sel        <= ~pub_sel;
                bus.sent_len   <= len;
                bus.sent_valid <= 1'b1;
            end else if (bus.sent_ack) begin
                bus.sent_valid <= 1'b0;
            end
        end
    end

    nmea_line_buffer #(.MAX_LEN(MAX_LEN), .AW(AW)) u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (buf_we),
        .wr_sel  (~pub_sel),
        .wr_addr (AW'(len)),
        .wr_data (bus.rx_data),
        .rd_sel  (pub_sel),
        .rd_addr (bus.rd_addr),
        .rd_data (bus.rd_data)
    );
endmodule

// File: tb/tb_nmea_sentence_framer.sv
// Directed bench for nmea_sentence_framer with hand-computed checksums
// ('A'^'B'=0x03, 'C'^'D'=0x07, 'E'^'F'=0x03). Timeout is shortened.
module tb_nmea_sentence_framer;
    localparam int MAX_LEN = 82;
    localparam int TMO     = 200;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #10 clk = ~clk;

    nmea_sentence_framer_if #(.MAX_LEN(MAX_LEN)) bus ();

    nmea_sentence_framer #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TMO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ack);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        bus.sent_ack = ack;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.sent_ack = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b0);
    endtask

    task automatic ack();
        @(negedge clk);
        bus.sent_ack = 1'b1;
        @(negedge clk);
        bus.sent_ack = 1'b0;
    endtask

    task automatic err_pulse();
        @(negedge clk);
        bus.rx_err = 1'b1;
        @(negedge clk);
        bus.rx_err = 1'b0;
    endtask

    task automatic check_rd(input string tag, input int addr, input int exp);
        @(negedge clk);
        bus.rd_addr = addr[6:0];
        @(negedge clk);
        check(tag, int'(bus.rd_data), exp);
    endtask

    task automatic check_cnts(input string tag, input int cs, input int fmt, input int drop);
        check({tag, ".cs"},   int'(bus.cs_err_cnt),  cs);
        check({tag, ".fmt"},  int'(bus.fmt_err_cnt), fmt);
        check({tag, ".drop"}, int'(bus.drop_cnt),    drop);
    endtask

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.rx_err   = 1'b0;
        bus.sent_ack = 1'b0;
        bus.rd_addr  = '0;
        repeat (3) @(negedge clk);
        check("rst.valid", int'(bus.sent_valid), 0);
        check("rst.len",   int'(bus.sent_len),   0);
        check("rst.rd",    int'(bus.rd_data),    0);
        check_cnts("rst", 0, 0, 0);
        reset_n = 1'b1;

        // Basic sentence and publish latency on the terminating byte.
        send_str("$AB*03");
        send_byte(8'h0D, 1'b0);
`ifdef NMEA_CRLF_STRICT_EN
        check("ab.cr_only", int'(bus.sent_valid), 0);
        send_byte(8'h0A, 1'b0);
        check("ab.lat", int'(bus.sent_valid), 1);
`else
        check("ab.lat", int'(bus.sent_valid), 1);
        send_byte(8'h0A, 1'b0);
`endif
        check("ab.len", int'(bus.sent_len), 2);
        check_rd("ab.rd0", 0, 8'h41);
        check_rd("ab.rd1", 1, 8'h42);
        check_cnts("ab", 0, 0, 0);
        ack();
        check("ab.ack", int'(bus.sent_valid), 0);

        // Checksum mismatch.
        send_str("$AB*04\r\n");
        check("cs.valid", int'(bus.sent_valid), 0);
        check_cnts("cs", 1, 0, 0);

        // Overlong body aborts; next sentence is fine.
        send_byte(8'h24, 1'b0);
        for (int i = 0; i < MAX_LEN + 1; i++) send_byte(8'h58, 1'b0);
        check("long.fmt",   int'(bus.fmt_err_cnt), 1);
        check("long.valid", int'(bus.sent_valid),  0);
        send_str("$AB*03\r\n");
        check("long.next", int'(bus.sent_valid), 1);
        check("long.len",  int'(bus.sent_len),   2);

        // Busy slot: second sentence dropped, published body unchanged.
        send_str("$CD*07\r\n");
        check_cnts("drop", 1, 1, 1);
        check("drop.len", int'(bus.sent_len), 2);
        check_rd("drop.rd0", 0, 8'h41);
        check_rd("drop.rd1", 1, 8'h42);
        ack();
        send_str("$CD*07\r\n");
        check("cd.valid", int'(bus.sent_valid), 1);
        check_rd("cd.rd0", 0, 8'h43);
        check_rd("cd.rd1", 1, 8'h44);
        ack();

        // '$' mid-sentence restarts.
        send_str("$AB*0$CD*07\r\n");
        check("restart.fmt",   int'(bus.fmt_err_cnt), 2);
        check("restart.valid", int'(bus.sent_valid),  1);
        check_rd("restart.rd0", 0, 8'h43);

        // Ack in the same cycle as completion: release then publish, no drop.
        send_str("$EF*03");
`ifdef NMEA_CRLF_STRICT_EN
        send_byte(8'h0D, 1'b0);
        send_byte(8'h0A, 1'b1);
`else
        send_byte(8'h0D, 1'b1);
        send_byte(8'h0A, 1'b0);
`endif
        check("same.valid", int'(bus.sent_valid), 1);
        check_cnts("same", 1, 2, 1);
        check_rd("same.rd0", 0, 8'h45);
        check_rd("same.rd1", 1, 8'h46);
        ack();

        // Lower-case hex checksum.
        send_str("$Z*5a\r\n");
        check("lc.valid", int'(bus.sent_valid), 1);
        check("lc.len",   int'(bus.sent_len),   1);
        check_rd("lc.rd0", 0, 8'h5A);
        ack();

        // Exactly MAX_LEN body bytes is accepted (even count of 'X' -> XOR 00).
        send_byte(8'h24, 1'b0);
        for (int i = 0; i < MAX_LEN; i++) send_byte(8'h58, 1'b0);
        send_str("*00\r\n");
        check("max.valid", int'(bus.sent_valid), 1);
        check("max.len",   int'(bus.sent_len),   MAX_LEN);
        check_rd("max.last", MAX_LEN - 1, 8'h58);
        check("max.fmt", int'(bus.fmt_err_cnt), 2);
        ack();

        // Gap just under the timeout is tolerated.
        send_str("$AB");
        repeat (TMO - 5) @(negedge clk);
        send_str("*03\r\n");
        check("tmo_ok.valid", int'(bus.sent_valid),  1);
        check("tmo_ok.fmt",   int'(bus.fmt_err_cnt), 2);
        ack();

        // Timeout aborts; trailing bytes are ignored back in IDLE.
        send_str("$AB");
        repeat (TMO + 10) @(negedge clk);
        check("tmo.fmt", int'(bus.fmt_err_cnt), 3);
        send_str("*03\r\n");
        check("tmo.valid", int'(bus.sent_valid), 0);
        check_cnts("tmo", 1, 3, 1);

        // UART error aborts inside a sentence, ignored in IDLE.
        send_str("$AB");
        err_pulse();
        send_str("*03\r\n");
        check("rxerr.fmt",   int'(bus.fmt_err_cnt), 4);
        check("rxerr.valid", int'(bus.sent_valid),  0);
        err_pulse();
        check("rxerr.idle", int'(bus.fmt_err_cnt), 4);

        // Reset mid-sentence with a sentence published.
        send_str("$AB*03\r\n");
        check("pre_rst.valid", int'(bus.sent_valid), 1);
        send_str("$CD");
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("mrst.valid", int'(bus.sent_valid), 0);
        check("mrst.len",   int'(bus.sent_len),   0);
        check("mrst.rd",    int'(bus.rd_data),    0);
        check_cnts("mrst", 0, 0, 0);
        reset_n = 1'b1;
        send_str("*07\r\n");
        check("post_rst.valid", int'(bus.sent_valid),  0);
        check("post_rst.fmt",   int'(bus.fmt_err_cnt), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
